// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divided-clock checker.
package clk_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StLocked
  } state_e;

  // Smallest divide ratio that can be checked; 0 and 1 are rejected.
  localparam int unsigned MinDiv      = 2;
  // A missing edge is declared after this many nominal periods.
  localparam int unsigned TimeoutMult = 2;

endpackage

// File: rtl/edge_det.sv
// Registers the monitored signal and flags its rising edge in the same cycle it arrives.
module edge_det (
  input  logic clk_i,
  input  logic clr_i,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Previous-cycle copy of the monitored signal; cleared so the first high after clear is an edge.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/clk_div_checker.sv
// Measures the period of a divided clock / enable train and checks it against div_i.
module clk_div_checker
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_i,
  input  logic             sig_in,
  output logic [DIV_W-1:0] period_o,
  output logic             period_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic             timeout,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned CntW = DIV_W + 1;
  // Wide enough for cnt+1 and TimeoutMult*div_i without overflow.
  localparam int unsigned ExtW = DIV_W + 2;
  localparam int unsigned RunW = 8;

  logic soft_rst;
  logic rise;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [RunW-1:0]  run_q, run_d, run_inc;
  logic [DIV_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             timeout_q, timeout_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [ExtW-1:0]  cnt_inc;
  logic [ExtW-1:0]  tmo_lim;
  logic [DIV_W-1:0] period;
  logic             div_ok;
  logic             err_event;

  assign soft_rst = reset | clr;

  edge_det u_edge_det (
    .clk_i  (clk),
    .clr_i  (soft_rst),
    .sig_i  (sig_in),
    .rise_o (rise)
  );

  // Next-state for the FSM, cycle counter, lock run and error bookkeeping.
  always_comb begin
    cnt_inc = ExtW'(cnt_q) + ExtW'(1);
    tmo_lim = ExtW'(div_i) * ExtW'(TimeoutMult);
    period  = (cnt_inc > ExtW'({DIV_W{1'b1}})) ? {DIV_W{1'b1}} : cnt_inc[DIV_W-1:0];
    div_ok  = ExtW'(div_i) >= ExtW'(MinDiv);
    run_inc = (run_q < RunW'(LOCK_CNT)) ? run_q + RunW'(1) : run_q;

    state_d        = state_q;
    run_d          = run_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    timeout_d      = 1'b0;
    err_event      = 1'b0;

    if (rise) begin
      cnt_d = '0;
    end else if (cnt_q == {CntW{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        // First edge only establishes the reference; nothing to compare yet.
        if (div_ok && rise) begin
          state_d = StMeasure;
        end
      end
      StMeasure, StLocked: begin
        if (!div_ok) begin
          state_d  = StIdle;
          locked_d = 1'b0;
          run_d    = '0;
        end else if (rise) begin
          period_d       = period;
          period_valid_d = 1'b1;
          if (period == div_i) begin
            run_d = run_inc;
            if (run_inc == RunW'(LOCK_CNT)) begin
              locked_d = 1'b1;
              state_d  = StLocked;
            end
          end else begin
            run_d     = '0;
            locked_d  = 1'b0;
            state_d   = StMeasure;
            err_event = 1'b1;
          end
        end else if (cnt_inc >= tmo_lim) begin
          timeout_d = 1'b1;
          err_event = 1'b1;
          locked_d  = 1'b0;
          run_d     = '0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        locked_d = 1'b0;
        run_d    = '0;
      end
    endcase

    err_pulse_d = err_event;
    if (err_event && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers; reset and clr are equivalent.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      run_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      timeout_q      <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      run_q          <= run_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      err_pulse_q    <= err_pulse_d;
      timeout_q      <= timeout_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign period_o     = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign err_pulse    = err_pulse_q;
  assign timeout      = timeout_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_clk_div_checker.sv
// Directed bench for clk_div_checker: lock, mismatch, timeout, invalid ratio, clear, saturation.
module tb_clk_div_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic [7:0] div_i;
  logic       sig_in;

  logic [7:0] period_o;
  logic       period_valid, locked, err_pulse, timeout;
  logic [7:0] err_cnt;

  logic [7:0] s_period_o;
  logic       s_period_valid, s_locked, s_err_pulse, s_timeout;
  logic [1:0] s_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_checker #(
    .DIV_W    (8),
    .LOCK_CNT (4),
    .ERR_W    (8)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .clr          (clr),
    .div_i        (div_i),
    .sig_in       (sig_in),
    .period_o     (period_o),
    .period_valid (period_valid),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .timeout      (timeout),
    .err_cnt      (err_cnt)
  );

  // Narrow error counter instance for the saturation check.
  clk_div_checker #(
    .DIV_W    (8),
    .LOCK_CNT (4),
    .ERR_W    (2)
  ) u_dut_sat (
    .clk          (clk),
    .reset        (reset),
    .clr          (clr),
    .div_i        (div_i),
    .sig_in       (sig_in),
    .period_o     (s_period_o),
    .period_valid (s_period_valid),
    .locked       (s_locked),
    .err_pulse    (s_err_pulse),
    .timeout      (s_timeout),
    .err_cnt      (s_err_cnt)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one sample, let the edge take it, then look just after the edge.
  task automatic step(input logic v);
    sig_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic period3();
    step(1'b1);
    step(1'b0);
    step(1'b1);
  endtask

  task automatic period4();
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1'b0);
    clr = 1'b0;
  endtask

  int pv_seen;
  int err_seen;

  initial begin
    reset  = 1'b1;
    clr    = 1'b0;
    div_i  = 8'd3;
    sig_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check_eq("rst_period", 32'(period_o), 0);
    check_eq("rst_pv", 32'(period_valid), 0);
    check_eq("rst_locked", 32'(locked), 0);
    check_eq("rst_err_pulse", 32'(err_pulse), 0);
    check_eq("rst_timeout", 32'(timeout), 0);
    check_eq("rst_err_cnt", 32'(err_cnt), 0);

    // Lock to divide-by-3.
    step(1'b0);
    step(1'b1);
    check_eq("ref_no_pv", 32'(period_valid), 0);
    for (int i = 1; i <= 4; i++) begin
      period3();
      check_eq("lock_pv", 32'(period_valid), 1);
      check_eq("lock_period", 32'(period_o), 3);
      check_eq("lock_locked", 32'(locked), (i == 4) ? 1 : 0);
    end
    check_eq("lock_err_cnt", 32'(err_cnt), 0);

    // Stretched period while locked.
    period4();
    check_eq("mm_pv", 32'(period_valid), 1);
    check_eq("mm_period", 32'(period_o), 4);
    check_eq("mm_err_pulse", 32'(err_pulse), 1);
    check_eq("mm_locked", 32'(locked), 0);
    check_eq("mm_err_cnt", 32'(err_cnt), 1);
    step(1'b1);
    check_eq("mm_pulse_1cyc", 32'(err_pulse), 0);
    step(1'b0);
    step(1'b1);
    check_eq("relock_1", 32'(locked), 0);
    for (int i = 2; i <= 4; i++) begin
      period3();
      check_eq("relock_period", 32'(period_o), 3);
      check_eq("relock_locked", 32'(locked), (i == 4) ? 1 : 0);
    end

    // Held low after the last edge: timeout when cnt+1 reaches 6.
    for (int k = 1; k <= 6; k++) begin
      step(1'b0);
      if (k == 5) check_eq("tmo_early", 32'(timeout), 0);
    end
    check_eq("tmo_timeout", 32'(timeout), 1);
    check_eq("tmo_err_pulse", 32'(err_pulse), 1);
    check_eq("tmo_locked", 32'(locked), 0);
    check_eq("tmo_err_cnt", 32'(err_cnt), 2);
    step(1'b0);
    check_eq("tmo_pulse_1cyc", 32'(timeout), 0);
    step(1'b1);
    check_eq("tmo_idle_ref", 32'(period_valid), 0);
    period3();
    check_eq("tmo_remeasure_pv", 32'(period_valid), 1);
    check_eq("tmo_remeasure_per", 32'(period_o), 3);

    // Held high also times out.
    for (int k = 1; k <= 6; k++) step(1'b1);
    check_eq("hi_timeout", 32'(timeout), 1);
    check_eq("hi_err_cnt", 32'(err_cnt), 3);

    // Rise lands on the timeout cycle: compare wins.
    step(1'b0);
    step(1'b1);
    check_eq("col_ref", 32'(period_valid), 0);
    for (int k = 1; k <= 5; k++) step(1'b0);
    step(1'b1);
    check_eq("col_timeout", 32'(timeout), 0);
    check_eq("col_pv", 32'(period_valid), 1);
    check_eq("col_period", 32'(period_o), 6);
    check_eq("col_err_pulse", 32'(err_pulse), 1);
    check_eq("col_err_cnt", 32'(err_cnt), 4);

    // clr together with a rise.
    step(1'b0);
    clr = 1'b1;
    step(1'b1);
    clr = 1'b0;
    check_eq("clr_period", 32'(period_o), 0);
    check_eq("clr_pv", 32'(period_valid), 0);
    check_eq("clr_locked", 32'(locked), 0);
    check_eq("clr_err_pulse", 32'(err_pulse), 0);
    check_eq("clr_err_cnt", 32'(err_cnt), 0);
    step(1'b1);
    check_eq("clr_fresh_ref", 32'(period_valid), 0);
    period3();
    check_eq("clr_pv_after", 32'(period_valid), 1);
    check_eq("clr_period_after", 32'(period_o), 3);
    check_eq("clr_err_after", 32'(err_pulse), 0);

    // Invalid ratio, entered from MEASURE.
    do_clr();
    step(1'b1);
    div_i    = 8'd1;
    pv_seen  = 0;
    err_seen = 0;
    for (int k = 0; k < 16; k++) begin
      step(k[0]);
      pv_seen  += int'(period_valid);
      err_seen += int'(err_pulse);
    end
    check_eq("inv_pv", pv_seen, 0);
    check_eq("inv_err", err_seen, 0);
    check_eq("inv_locked", 32'(locked), 0);
    check_eq("inv_err_cnt", 32'(err_cnt), 0);

    // Error counter saturation with five mismatches.
    div_i = 8'd3;
    do_clr();
    step(1'b1);
    for (int i = 0; i < 5; i++) period4();
    check_eq("sat_wide_cnt", 32'(err_cnt), 5);
    check_eq("sat_narrow_cnt", 32'(s_err_cnt), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
